avalon_ram_arbiter: RTL and testbench

- N-master to 1-slave Avalon-MM arbiter placed directly upstream of the main-memory port (BRAM or SRAM controller).
- Lets the debug host, ibus and dbus share one memory slave without a full interconnect path.
- Grant is registered and held for the whole transfer; a slave with multi-cycle waitrequest (SRAM) is never exposed to a master switch mid-transfer.

---
 rtl/soc_arb_pkg.sv | 14 +
 rtl/arb_rr_select.sv | 49 ++++
 rtl/avalon_ram_arbiter.sv | 129 ++++++++++++
 tb/tb_avalon_ram_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_arb_pkg.sv
// Shared definitions for the memory-port arbiter: FSM state encoding and
// the fixed master index assignment (debug host, ibus, dbus).
package soc_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  localparam int unsigned MST_DEBUG = 0;
  localparam int unsigned MST_IBUS  = 1;
  localparam int unsigned MST_DBUS  = 2;

endpackage

// File: rtl/arb_rr_select.sv
// Combinational winner selection for the memory-port arbiter.
// Default: round-robin starting at rr_ptr with wrap-around.
// ARB_FIXED_PRIORITY_EN: lowest requesting index wins, rr_ptr ignored.
module arb_rr_select #(
  parameter int unsigned NUM_MASTER = 3,
  parameter int unsigned PW         = (NUM_MASTER > 1) ? $clog2(NUM_MASTER) : 1
) (
  input  logic [NUM_MASTER-1:0] req,
  input  logic [PW-1:0]         rr_ptr,
  output logic [NUM_MASTER-1:0] grant
);

`ifdef ARB_FIXED_PRIORITY_EN
  logic unused_rr_ptr;
  assign unused_rr_ptr = ^rr_ptr;

  // Lowest requesting index wins; scanning downward lets the last hit stand.
  always_comb begin
    grant = '0;
    for (int unsigned i = NUM_MASTER; i > 0; i--) begin
      if (req[i-1]) begin
        grant        = '0;
        grant[i-1]   = 1'b1;
      end
    end
  end
`else
  // Two ascending passes replace modular index arithmetic: the first pass
  // covers indices >= rr_ptr, the second covers the wrapped-around remainder.
  always_comb begin
    logic found;
    grant = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_MASTER; i++) begin
      if (!found && req[i] && (PW'(i) >= rr_ptr)) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int unsigned i = 0; i < NUM_MASTER; i++) begin
      if (!found && req[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/avalon_ram_arbiter.sv
// N-master to 1-slave Avalon-MM arbiter in front of the main-memory port.
// The grant is registered and held until the slave completes the transfer,
// so a multi-cycle waitrequest slave never sees a master switch mid-transfer.
// Optional macro ARB_FIXED_PRIORITY_EN selects fixed priority (index 0
// highest) instead of round-robin and removes the rr_ptr register.
module avalon_ram_arbiter #(
  parameter int unsigned NUM_MASTER = 3,
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_MASTER-1:0]          m_read,
  input  logic [NUM_MASTER-1:0]          m_write,
  input  logic [NUM_MASTER*AW-1:0]       m_address,
  input  logic [NUM_MASTER*(DW/8)-1:0]   m_byte_enable,
  input  logic [NUM_MASTER*DW-1:0]       m_writedata,
  output logic [DW-1:0]                  m_readdata,
  output logic [NUM_MASTER-1:0]          m_waitrequest,
  output logic                           s_read,
  output logic                           s_write,
  output logic [AW-1:0]                  s_address,
  output logic [DW/8-1:0]                s_byte_enable,
  output logic [DW-1:0]                  s_writedata,
  input  logic [DW-1:0]                  s_readdata,
  input  logic                           s_waitrequest
);
  import soc_arb_pkg::*;

  localparam int unsigned PW = (NUM_MASTER > 1) ? $clog2(NUM_MASTER) : 1;
  localparam int unsigned BW = DW / 8;

  arb_state_e            state;
  logic [NUM_MASTER-1:0] grant;
  logic [NUM_MASTER-1:0] req;
  logic [NUM_MASTER-1:0] winner;
  logic                  granted_req;
  logic                  busy;

  assign req         = m_read | m_write;
  assign busy        = (state == ARB_BUSY);
  assign granted_req = |(req & grant);
  assign m_readdata  = s_readdata;

`ifdef ARB_FIXED_PRIORITY_EN
  localparam logic [PW-1:0] rr_ptr = '0;
`else
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] grant_idx;
  logic [PW-1:0] next_ptr;

  // Encode the one-hot grant and compute the slot after it, wrapping to 0.
  always_comb begin
    grant_idx = '0;
    for (int unsigned i = 0; i < NUM_MASTER; i++) begin
      if (grant[i]) grant_idx = PW'(i);
    end
    next_ptr = (grant_idx == PW'(NUM_MASTER - 1)) ? '0 : grant_idx + PW'(1);
  end

  // Advance the round-robin pointer only on a real completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (busy && granted_req && !s_waitrequest) begin
      rr_ptr <= next_ptr;
    end
  end
`endif

  arb_rr_select #(
    .NUM_MASTER (NUM_MASTER),
    .PW         (PW)
  ) u_select (
    .req    (req),
    .rr_ptr (rr_ptr),
    .grant  (winner)
  );

  // Arbitration FSM: grab a winner when idle, release on completion or when
  // the granted master abandons its request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB_IDLE;
      grant <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (|req) begin
            grant <= winner;
            state <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (!granted_req || !s_waitrequest) begin
            grant <= '0;
            state <= ARB_IDLE;
          end
        end
        default: begin
          grant <= '0;
          state <= ARB_IDLE;
        end
      endcase
    end
  end

  // Slave-side mux from the granted master; grant is zero while idle, so the
  // slave bus reads as all-zero then and drops as soon as reset clears grant.
  always_comb begin
    s_read        = 1'b0;
    s_write       = 1'b0;
    s_address     = '0;
    s_byte_enable = '0;
    s_writedata   = '0;
    m_waitrequest = '1;
    for (int unsigned i = 0; i < NUM_MASTER; i++) begin
      if (grant[i]) begin
        s_read           = s_read  | (m_read[i]  & busy);
        s_write          = s_write | (m_write[i] & busy);
        s_address        = s_address     | m_address[i*AW +: AW];
        s_byte_enable    = s_byte_enable | m_byte_enable[i*BW +: BW];
        s_writedata      = s_writedata   | m_writedata[i*DW +: DW];
        m_waitrequest[i] = busy ? s_waitrequest : 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_avalon_ram_arbiter.sv
// Scoreboard bench for avalon_ram_arbiter: stimulus pushes expected
// completions (master, kind, address, data, byte enable, read data) in the
// order they must occur; a monitor pops one per observed completion.
module tb_avalon_ram_arbiter;
  import soc_arb_pkg::*;

  localparam int NM = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NM-1:0]     m_read = '0;
  logic [NM-1:0]     m_write = '0;
  logic [NM*AW-1:0]  m_address = '0;
  logic [NM*BW-1:0]  m_byte_enable = '0;
  logic [NM*DW-1:0]  m_writedata = '0;
  logic [DW-1:0]     m_readdata;
  logic [NM-1:0]     m_waitrequest;
  logic              s_read;
  logic              s_write;
  logic [AW-1:0]     s_address;
  logic [BW-1:0]     s_byte_enable;
  logic [DW-1:0]     s_writedata;
  logic [DW-1:0]     s_readdata;
  logic              s_waitrequest;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int unsigned slave_wait = 0;
  int unsigned wcnt = 0;

  typedef struct {
    int          mst;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   done_cyc[$];

  always #5 clk = ~clk;

  avalon_ram_arbiter #(.NUM_MASTER(NM), .AW(AW), .DW(DW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .m_read        (m_read),
    .m_write       (m_write),
    .m_address     (m_address),
    .m_byte_enable (m_byte_enable),
    .m_writedata   (m_writedata),
    .m_readdata    (m_readdata),
    .m_waitrequest (m_waitrequest),
    .s_read        (s_read),
    .s_write       (s_write),
    .s_address     (s_address),
    .s_byte_enable (s_byte_enable),
    .s_writedata   (s_writedata),
    .s_readdata    (s_readdata),
    .s_waitrequest (s_waitrequest)
  );

  // Slave model: waits slave_wait cycles per strobe, returns DEADBEEF at 0x10
  // and the inverted address elsewhere.
  assign s_waitrequest = (s_read | s_write) && (wcnt < slave_wait);
  assign s_readdata    = (s_address == 32'h10) ? 32'hDEADBEEF : ~s_address;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if ((s_read | s_write) && s_waitrequest) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic push(input int mst, input logic wr, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] be, input logic [31:0] rdata);
    exp_t e;
    e.mst = mst; e.wr = wr; e.addr = addr; e.data = data; e.be = be; e.rdata = rdata;
    exp_q.push_back(e);
  endtask

  // Monitor: a completion is read|write asserted with waitrequest low.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      for (int i = 0; i < NM; i++) begin
        if (!m_waitrequest[i] && (m_read[i] | m_write[i])) begin
          done_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_completion master=%0d expected=none", i);
          end else begin
            e = exp_q.pop_front();
            check("grant_order", 32'(i), 32'(e.mst));
            check("s_write", {31'd0, s_write}, {31'd0, e.wr});
            check("s_read", {31'd0, s_read}, {31'd0, !e.wr});
            check("s_address", s_address, e.addr);
            check("s_byte_enable", {28'd0, s_byte_enable}, {28'd0, e.be});
            if (e.wr) check("s_writedata", s_writedata, e.data);
            else check("m_readdata", m_readdata, e.rdata);
          end
        end
      end
    end
  end

  // One master issuing n back-to-back accesses at base, base+4, ...
  // Write data is address ^ A5A50000.
  task automatic master_run(input int idx, input int n, input logic wr,
                            input logic [31:0] base, input logic [3:0] be);
    int t;
    for (int k = 0; k < n; k++) begin
      m_read[idx]                  = !wr;
      m_write[idx]                 = wr;
      m_address[idx*AW +: AW]      = base + 32'(k * 4);
      m_writedata[idx*DW +: DW]    = (base + 32'(k * 4)) ^ 32'hA5A5_0000;
      m_byte_enable[idx*BW +: BW]  = be;
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (m_waitrequest[idx] && t < 60);
      if (m_waitrequest[idx]) check("access_timeout", 32'(idx), 32'hFFFF_FFFF);
      @(posedge clk);
      #1;
    end
    m_read[idx]  = 1'b0;
    m_write[idx] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, with requests present to prove nothing is granted.
    m_read = 3'b111;
    repeat (2) @(negedge clk);
    check("rst_s_read", {31'd0, s_read}, 32'd0);
    check("rst_s_write", {31'd0, s_write}, 32'd0);
    check("rst_waitreq", {29'd0, m_waitrequest}, 32'd7);
    check("rst_s_address", s_address, 32'd0);
    m_read = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single ibus read of 0x10, zero-wait slave.
    push(MST_IBUS, 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF);
    @(posedge clk); #1;
    m_read[1] = 1'b1;
    m_address[1*AW +: AW] = 32'h10;
    m_byte_enable[1*BW +: BW] = 4'hF;
    @(negedge clk);
    check("t1_c1_s_read", {31'd0, s_read}, 32'd0);
    check("t1_c1_waitreq", {29'd0, m_waitrequest}, 32'd7);
    @(negedge clk);
    check("t1_c2_s_read", {31'd0, s_read}, 32'd1);
    check("t1_c2_waitreq", {29'd0, m_waitrequest}, 32'd5);
    @(posedge clk); #1;
    m_read[1] = 1'b0;
    @(negedge clk);
    check("t1_c3_s_read", {31'd0, s_read}, 32'd0);
    check("t1_c3_waitreq", {29'd0, m_waitrequest}, 32'd7);

    // rr_ptr=2: ibus and dbus together, dbus first.
    push(MST_DBUS, 1'b0, 32'h80, 32'h0, 4'hF, 32'hFFFF_FF7F);
    push(MST_IBUS, 1'b0, 32'h40, 32'h0, 4'hF, 32'hFFFF_FFBF);
    @(posedge clk); #1;
    fork
      master_run(1, 1, 1'b0, 32'h40, 4'hF);
      master_run(2, 1, 1'b0, 32'h80, 4'hF);
    join

    // dbus write with three slave wait cycles.
    slave_wait = 3;
    push(MST_DBUS, 1'b1, 32'h100, 32'h12345678, 4'h3, 32'h0);
    @(posedge clk); #1;
    m_write[2] = 1'b1;
    m_address[2*AW +: AW] = 32'h100;
    m_writedata[2*DW +: DW] = 32'h12345678;
    m_byte_enable[2*BW +: BW] = 4'h3;
    @(negedge clk);
    check("t4_c1_s_write", {31'd0, s_write}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t4_s_write", {31'd0, s_write}, 32'd1);
      check("t4_s_address", s_address, 32'h100);
      check("t4_s_writedata", s_writedata, 32'h12345678);
      check("t4_s_be", {28'd0, s_byte_enable}, 32'h3);
      check("t4_waitreq", {29'd0, m_waitrequest}, (k == 3) ? 32'd3 : 32'd7);
    end
    @(posedge clk); #1;
    m_write[2] = 1'b0;

    // Reset pulsed mid-transfer while the slave stalls.
    slave_wait = 10;
    m_read[2] = 1'b1;
    m_address[2*AW +: AW] = 32'h200;
    @(negedge clk);
    @(negedge clk);
    check("t5_busy_s_read", {31'd0, s_read}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("t5_async_s_read", {31'd0, s_read}, 32'd0);
    check("t5_async_s_write", {31'd0, s_write}, 32'd0);
    check("t5_async_waitreq", {29'd0, m_waitrequest}, 32'd7);
    check("t5_async_s_address", s_address, 32'd0);
    m_read[2] = 1'b0;
    #1 rst_n = 1'b1;
    slave_wait = 0;
    @(negedge clk);
    check("t5_post_waitreq", {29'd0, m_waitrequest}, 32'd7);

    // All masters continuous after reset: 0,1,2,0,1,2, one completion per 2 cycles.
    push(MST_DEBUG, 1'b0, 32'h1000, 32'h0,         4'hF, 32'hFFFF_EFFF);
    push(MST_IBUS,  1'b1, 32'h2000, 32'hA5A5_2000, 4'hF, 32'h0);
    push(MST_DBUS,  1'b0, 32'h3000, 32'h0,         4'hF, 32'hFFFF_CFFF);
    push(MST_DEBUG, 1'b0, 32'h1004, 32'h0,         4'hF, 32'hFFFF_EFFB);
    push(MST_IBUS,  1'b1, 32'h2004, 32'hA5A5_2004, 4'hF, 32'h0);
    push(MST_DBUS,  1'b0, 32'h3004, 32'h0,         4'hF, 32'hFFFF_CFFB);
    @(posedge clk); #1;
    done_cyc.delete();
    fork
      master_run(0, 2, 1'b0, 32'h1000, 4'hF);
      master_run(1, 2, 1'b1, 32'h2000, 4'hF);
      master_run(2, 2, 1'b0, 32'h3000, 4'hF);
    join
    check("t6_completions", 32'(done_cyc.size()), 32'd6);
    for (int k = 1; k < done_cyc.size(); k++)
      check("t6_spacing", 32'(done_cyc[k] - done_cyc[k-1]), 32'd2);

    // Put rr_ptr at 2, then dbus abandons its granted read.
    push(MST_IBUS, 1'b0, 32'h44, 32'h0, 4'hF, 32'hFFFF_FFBB);
    master_run(1, 1, 1'b0, 32'h44, 4'hF);
    slave_wait = 5;
    m_read[2] = 1'b1;
    m_address[2*AW +: AW] = 32'h300;
    @(negedge clk);
    @(negedge clk);
    check("t7_busy_s_read", {31'd0, s_read}, 32'd1);
    @(posedge clk); #1;
    m_read[2] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t7_idle_waitreq", {29'd0, m_waitrequest}, 32'd7);
    check("t7_idle_s_read", {31'd0, s_read}, 32'd0);
    slave_wait = 0;
    push(MST_DBUS, 1'b0, 32'h84, 32'h0, 4'hF, 32'hFFFF_FF7B);
    push(MST_IBUS, 1'b0, 32'h48, 32'h0, 4'hF, 32'hFFFF_FFB7);
    @(posedge clk); #1;
    fork
      master_run(1, 1, 1'b0, 32'h48, 4'hF);
      master_run(2, 1, 1'b0, 32'h84, 4'hF);
    join

    repeat (2) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
